// File: rtl/axil4_mmio_slave.sv
// AXI-Lite-4 MMIO responder: scratch register, free-running 64-bit
// cycle counter and sticky halt flag exposed as one 128-bit line.
module axil4_mmio_slave #(
    parameter logic [31:0] BASE_ADDR = 32'hFFFF_0000
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [31:0]  readAddr_addr,
    input  logic         readAddr_valid,
    output logic         readAddr_ready,
    output logic [127:0] readData_data,
    output logic         readData_valid,
    input  logic         readData_ready,
    input  logic [31:0]  writeAddr_addr,
    input  logic         writeAddr_valid,
    output logic         writeAddr_ready,
    input  logic [127:0] writeData_data,
    input  logic [15:0]  writeData_strb,
    input  logic         writeData_valid,
    output logic         writeData_ready,
    output logic [31:0]  writeResp_msg,
    output logic         writeResp_valid,
    input  logic         writeResp_ready,
    output logic         halt_req
);

    typedef enum logic {R_IDLE, R_RESP} r_state_t;
    typedef enum logic {W_COLLECT, W_RESP} w_state_t;

    r_state_t r_state, r_next;
    w_state_t w_state, w_next;

    logic [31:0]  scratch;
    logic         halt;
    logic [63:0]  cnt;
    logic [127:0] rdata;
    logic         r_hs, r_hit;

    logic         aw_got, w_got;
    logic [27:0]  aw_tag;
    logic [31:0]  w_data;
    logic         w_halt;
    logic [15:0]  w_strb;
    logic         msg;

    logic         aw_hs, w_hs, apply, w_hit, bad;
    logic [27:0]  tag_eff;
    logic [31:0]  data_eff;
    logic         halt_eff;
    logic [15:0]  strb_eff;

    logic unused;
    assign unused = ^{readAddr_addr[3:0], writeAddr_addr[3:0],
                      writeData_data[127:97], writeData_data[95:32]};

    // Read channel
    assign readAddr_ready = (r_state == R_IDLE);
    assign readData_valid = (r_state == R_RESP);
    assign readData_data  = rdata;
    assign r_hs  = readAddr_valid & readAddr_ready;
    assign r_hit = (readAddr_addr[31:4] == BASE_ADDR[31:4]);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= R_IDLE;
        else      r_state <= r_next;
    end

    always_comb begin
        r_next = r_state;
        unique case (r_state)
            R_IDLE: if (r_hs) r_next = R_RESP;
            R_RESP: if (readData_ready) r_next = R_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdata <= '0;
        end else if (r_hs) begin
            rdata <= r_hit ? {31'd0, halt, cnt, scratch} : '0;
        end
    end

    // Write channel: either item may arrive first; the one arriving
    // on the completing edge is taken straight from the bus.
    assign writeAddr_ready = (w_state == W_COLLECT) && !aw_got;
    assign writeData_ready = (w_state == W_COLLECT) && !w_got;
    assign writeResp_valid = (w_state == W_RESP);
    assign writeResp_msg   = {31'd0, msg};
    assign halt_req        = halt;

    assign aw_hs    = writeAddr_valid & writeAddr_ready;
    assign w_hs     = writeData_valid & writeData_ready;
    assign apply    = (w_state == W_COLLECT) && (aw_got || aw_hs) && (w_got || w_hs);
    assign tag_eff  = aw_got ? aw_tag : writeAddr_addr[31:4];
    assign data_eff = w_got ? w_data : writeData_data[31:0];
    assign halt_eff = w_got ? w_halt : writeData_data[96];
    assign strb_eff = w_got ? w_strb : writeData_strb;
    assign w_hit    = (tag_eff == BASE_ADDR[31:4]);
    assign bad      = (|strb_eff[11:4]) || (|strb_eff[15:13]);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) w_state <= W_COLLECT;
        else      w_state <= w_next;
    end

    always_comb begin
        w_next = w_state;
        unique case (w_state)
            W_COLLECT: if (apply) w_next = W_RESP;
            W_RESP:    if (writeResp_ready) w_next = W_COLLECT;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            aw_got  <= 1'b0;
            w_got   <= 1'b0;
            aw_tag  <= '0;
            w_data  <= '0;
            w_halt  <= 1'b0;
            w_strb  <= '0;
            msg     <= 1'b0;
            scratch <= '0;
            halt    <= 1'b0;
            cnt     <= '0;
        end else begin
            cnt <= cnt + 64'd1;
            if (aw_hs) begin
                aw_got <= 1'b1;
                aw_tag <= writeAddr_addr[31:4];
            end
            if (w_hs) begin
                w_got  <= 1'b1;
                w_data <= writeData_data[31:0];
                w_halt <= writeData_data[96];
                w_strb <= writeData_strb;
            end
            if (apply) begin
                msg <= !w_hit || bad;
                if (w_hit && !bad) begin
                    for (int i = 0; i < 4; i++)
                        if (strb_eff[i]) scratch[8*i +: 8] <= data_eff[8*i +: 8];
                    if (strb_eff[12] && halt_eff) halt <= 1'b1;
                end
            end
            if (w_state == W_RESP && writeResp_ready) begin
                aw_got <= 1'b0;
                w_got  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_axil4_mmio_slave.sv
// Randomized self-checking bench for axil4_mmio_slave against a
// register-level reference model.
module tb_axil4_mmio_slave;

    localparam logic [31:0] BASE = 32'hFFFF_0000;
    localparam logic [31:0] MISS = 32'h0000_1000;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [31:0]  readAddr_addr = '0;
    logic         readAddr_valid = 1'b0;
    logic         readAddr_ready;
    logic [127:0] readData_data;
    logic         readData_valid;
    logic         readData_ready = 1'b0;
    logic [31:0]  writeAddr_addr = '0;
    logic         writeAddr_valid = 1'b0;
    logic         writeAddr_ready;
    logic [127:0] writeData_data = '0;
    logic [15:0]  writeData_strb = '0;
    logic         writeData_valid = 1'b0;
    logic         writeData_ready;
    logic [31:0]  writeResp_msg;
    logic         writeResp_valid;
    logic         writeResp_ready = 1'b0;
    logic         halt_req;

    int compared = 0;
    int mismatched = 0;

    // Reference state
    logic [31:0]     m_scratch = '0;
    logic            m_halt = 1'b0;
    longint unsigned cyc = 0;

    axil4_mmio_slave #(.BASE_ADDR(BASE)) dut (
        .clk(clk), .rst(rst),
        .readAddr_addr(readAddr_addr), .readAddr_valid(readAddr_valid),
        .readAddr_ready(readAddr_ready),
        .readData_data(readData_data), .readData_valid(readData_valid),
        .readData_ready(readData_ready),
        .writeAddr_addr(writeAddr_addr), .writeAddr_valid(writeAddr_valid),
        .writeAddr_ready(writeAddr_ready),
        .writeData_data(writeData_data), .writeData_strb(writeData_strb),
        .writeData_valid(writeData_valid), .writeData_ready(writeData_ready),
        .writeResp_msg(writeResp_msg), .writeResp_valid(writeResp_valid),
        .writeResp_ready(writeResp_ready),
        .halt_req(halt_req)
    );

    always #5 clk = ~clk;

    // Cycles elapsed since reset release
    always @(posedge clk or negedge rst) begin
        if (!rst) cyc <= 0;
        else      cyc <= cyc + 1;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [127:0] model_line(input logic [31:0] a,
                                                input longint unsigned c);
        logic [63:0] c64;
        c64 = c;
        if (a[31:4] != BASE[31:4]) return '0;
        return {31'd0, m_halt, c64, m_scratch};
    endfunction

    function automatic logic [31:0] model_write(input logic [31:0] a,
                                                input logic [127:0] d,
                                                input logic [15:0] s);
        if (a[31:4] != BASE[31:4]) return 32'd1;
        if (s[11:4] != 8'd0 || s[15:13] != 3'd0) return 32'd1;
        for (int i = 0; i < 4; i++)
            if (s[i]) m_scratch[8*i +: 8] = d[8*i +: 8];
        if (s[12] && d[96]) m_halt = 1'b1;
        return 32'd0;
    endfunction

    task automatic do_read(input logic [31:0] a, output logic [127:0] d,
                           output longint unsigned c, output int lat);
        readAddr_addr  = a;
        readAddr_valid = 1'b1;
        readData_ready = 1'b1;
        c = cyc;
        tick;
        readAddr_valid = 1'b0;
        lat = 1;
        while (readData_valid !== 1'b1 && lat < 8) begin
            tick;
            lat++;
        end
        d = readData_data;
        tick;
    endtask

    task automatic do_write(input logic [31:0] a, input logic [127:0] d,
                            input logic [15:0] s, input int mode, input int gap,
                            output logic [31:0] msg, output int lat,
                            output logic h);
        writeResp_ready = 1'b0;
        writeAddr_addr  = a;
        writeData_data  = d;
        writeData_strb  = s;
        if (mode == 0) begin
            writeAddr_valid = 1'b1;
            writeData_valid = 1'b1;
            tick;
            writeAddr_valid = 1'b0;
            writeData_valid = 1'b0;
        end else if (mode == 1) begin
            writeData_valid = 1'b1;
            tick;
            writeData_valid = 1'b0;
            repeat (gap - 1) tick;
            writeAddr_valid = 1'b1;
            tick;
            writeAddr_valid = 1'b0;
        end else begin
            writeAddr_valid = 1'b1;
            tick;
            writeAddr_valid = 1'b0;
            repeat (gap - 1) tick;
            writeData_valid = 1'b1;
            tick;
            writeData_valid = 1'b0;
        end
        lat = 1;
        while (writeResp_valid !== 1'b1 && lat < 8) begin
            tick;
            lat++;
        end
        msg = writeResp_msg;
        h = halt_req;
        writeResp_ready = 1'b1;
        tick;
        writeResp_ready = 1'b0;
    endtask

    task automatic test_reset;
        logic [6:0] got;
        repeat (3) @(posedge clk);
        #1;
        got = {readAddr_ready, writeAddr_ready, writeData_ready,
               readData_valid, writeResp_valid, halt_req, 1'b0};
        compared++;
        if (got !== 7'b1110000) begin
            mismatched++;
            $display("FAIL reset_ctrl: got %b expected %b", got, 7'b1110000);
        end
        compared++;
        if (readData_data !== '0 || writeResp_msg !== '0) begin
            mismatched++;
            $display("FAIL reset_data: got data %h msg %h expected 0",
                     readData_data, writeResp_msg);
        end
        rst = 1'b1;
        m_scratch = '0;
        m_halt = 1'b0;
    endtask

    task automatic test_read_cnt;
        logic [127:0] d1, d2;
        longint unsigned c1, c2;
        int lat;
        repeat (4) tick;
        do_read(BASE, d1, c1, lat);
        compared++;
        if (lat !== 1) begin
            mismatched++;
            $display("FAIL read_latency: got %0d expected 1", lat);
        end
        compared++;
        if (d1 !== model_line(BASE, c1)) begin
            mismatched++;
            $display("FAIL read_line: got %h expected %h", d1, model_line(BASE, c1));
        end
        do_read(BASE, d2, c2, lat);
        compared++;
        if (d2[63:32] - d1[63:32] !== 32'd2) begin
            mismatched++;
            $display("FAIL read_b2b_delta: got %0d expected 2", d2[63:32] - d1[63:32]);
        end
    endtask

    task automatic test_write_scratch;
        logic [127:0] d;
        longint unsigned c;
        logic [31:0] msg;
        int lat;
        logic h;
        do_write(BASE, {96'd0, 32'hDEAD_BEEF}, 16'h000F, 1, 3, msg, lat, h);
        void'(model_write(BASE, {96'd0, 32'hDEAD_BEEF}, 16'h000F));
        compared++;
        if (lat !== 1 || msg !== 32'd0) begin
            mismatched++;
            $display("FAIL wr_scratch_resp: got lat %0d msg %0d expected 1 0", lat, msg);
        end
        compared++;
        if (writeResp_valid !== 1'b0) begin
            mismatched++;
            $display("FAIL wr_single_resp: got valid %b expected 0", writeResp_valid);
        end
        do_read(BASE, d, c, lat);
        compared++;
        if (d[31:0] !== 32'hDEAD_BEEF) begin
            mismatched++;
            $display("FAIL rd_scratch: got %h expected DEADBEEF", d[31:0]);
        end
    endtask

    task automatic test_byte_write;
        logic [127:0] d;
        longint unsigned c;
        logic [31:0] msg;
        int lat;
        logic h;
        do_write(BASE | 32'h4, {112'd0, 16'h1234}, 16'h0003, 0, 1, msg, lat, h);
        void'(model_write(BASE, {112'd0, 16'h1234}, 16'h0003));
        compared++;
        if (msg !== 32'd0) begin
            mismatched++;
            $display("FAIL byte_wr_msg: got %0d expected 0", msg);
        end
        do_read(BASE, d, c, lat);
        compared++;
        if (d[31:0] !== 32'hDEAD_1234) begin
            mismatched++;
            $display("FAIL byte_wr_scratch: got %h expected DEAD1234", d[31:0]);
        end
    endtask

    task automatic test_halt;
        logic [127:0] d, wd;
        longint unsigned c;
        logic [31:0] msg;
        int lat;
        logic h;
        compared++;
        if (halt_req !== 1'b0) begin
            mismatched++;
            $display("FAIL halt_pre: got %b expected 0", halt_req);
        end
        wd = '0;
        wd[96] = 1'b1;
        do_write(BASE, wd, 16'h1000, 2, 2, msg, lat, h);
        void'(model_write(BASE, wd, 16'h1000));
        compared++;
        if (h !== 1'b1 || msg !== 32'd0 || lat !== 1) begin
            mismatched++;
            $display("FAIL halt_set: got halt %b msg %0d lat %0d expected 1 0 1", h, msg, lat);
        end
        do_write(BASE, '0, 16'h1000, 0, 1, msg, lat, h);
        void'(model_write(BASE, '0, 16'h1000));
        compared++;
        if (halt_req !== 1'b1 || msg !== 32'd0) begin
            mismatched++;
            $display("FAIL halt_sticky: got halt %b msg %0d expected 1 0", halt_req, msg);
        end
        wd = {$urandom, $urandom, $urandom, $urandom};
        do_write(BASE, wd, 16'h00F0, 0, 1, msg, lat, h);
        void'(model_write(BASE, wd, 16'h00F0));
        compared++;
        if (msg !== 32'd1) begin
            mismatched++;
            $display("FAIL bad_strb_msg: got %0d expected 1", msg);
        end
        do_read(BASE, d, c, lat);
        compared++;
        if (d !== model_line(BASE, c)) begin
            mismatched++;
            $display("FAIL bad_strb_line: got %h expected %h", d, model_line(BASE, c));
        end
    endtask

    task automatic test_miss;
        logic [127:0] d;
        longint unsigned c;
        int lat;
        int bad_hold;
        do_read(MISS, d, c, lat);
        compared++;
        if (d !== '0) begin
            mismatched++;
            $display("FAIL miss_read: got %h expected 0", d);
        end
        writeResp_ready = 1'b0;
        writeAddr_addr  = MISS;
        writeData_data  = {4{32'hFFFF_FFFF}};
        writeData_strb  = 16'h000F;
        writeAddr_valid = 1'b1;
        writeData_valid = 1'b1;
        tick;
        writeAddr_valid = 1'b0;
        writeData_valid = 1'b0;
        bad_hold = 0;
        for (int i = 0; i < 5; i++) begin
            if (writeResp_valid !== 1'b1 || writeAddr_ready !== 1'b0 ||
                writeData_ready !== 1'b0) bad_hold++;
            tick;
        end
        compared++;
        if (bad_hold != 0) begin
            mismatched++;
            $display("FAIL miss_backpressure: got %0d bad cycles expected 0", bad_hold);
        end
        compared++;
        if (writeResp_msg !== 32'd1) begin
            mismatched++;
            $display("FAIL miss_msg: got %0d expected 1", writeResp_msg);
        end
        writeResp_ready = 1'b1;
        tick;
        writeResp_ready = 1'b0;
        compared++;
        if (writeResp_valid !== 1'b0 || writeAddr_ready !== 1'b1 || writeData_ready !== 1'b1) begin
            mismatched++;
            $display("FAIL miss_release: got valid %b readies %b%b expected 0 11",
                     writeResp_valid, writeAddr_ready, writeData_ready);
        end
    endtask

    task automatic test_concurrent;
        logic [127:0] exp_line, wd;
        logic [31:0] exp_msg;
        wd = {$urandom, $urandom, $urandom, $urandom};
        exp_line = model_line(BASE, cyc);
        exp_msg = model_write(BASE, wd, 16'h000F);
        readAddr_addr   = BASE;
        readAddr_valid  = 1'b1;
        writeAddr_addr  = BASE;
        writeData_data  = wd;
        writeData_strb  = 16'h000F;
        writeAddr_valid = 1'b1;
        writeData_valid = 1'b1;
        tick;
        readAddr_valid  = 1'b0;
        writeAddr_valid = 1'b0;
        writeData_valid = 1'b0;
        compared++;
        if (readData_valid !== 1'b1 || readData_data !== exp_line) begin
            mismatched++;
            $display("FAIL concurrent_read: got %b %h expected 1 %h",
                     readData_valid, readData_data, exp_line);
        end
        compared++;
        if (writeResp_valid !== 1'b1 || writeResp_msg !== exp_msg) begin
            mismatched++;
            $display("FAIL concurrent_write: got %b %0d expected 1 %0d",
                     writeResp_valid, writeResp_msg, exp_msg);
        end
        readData_ready  = 1'b1;
        writeResp_ready = 1'b1;
        tick;
        writeResp_ready = 1'b0;
    endtask

    task automatic test_random;
        logic [127:0] d, wd;
        logic [31:0] a, r, msg, exp_msg;
        logic [15:0] s;
        longint unsigned c;
        int lat;
        logic h;
        for (int n = 0; n < 60; n++) begin
            r = $urandom;
            a = (r[1:0] != 2'd0) ? {BASE[31:4], r[7:4]} : r;
            if ($urandom_range(0, 1) == 0) begin
                do_read(a, d, c, lat);
                compared++;
                if (lat !== 1 || d !== model_line(a, c)) begin
                    mismatched++;
                    $display("FAIL rand_read %0d: got lat %0d %h expected 1 %h",
                             n, lat, d, model_line(a, c));
                end
            end else begin
                wd = {$urandom, $urandom, $urandom, $urandom};
                r = $urandom;
                case ($urandom_range(0, 3))
                    0: s = {12'd0, r[3:0]};
                    1: s = 16'h1000 | {12'd0, r[3:0]};
                    2: s = r[31:16];
                    default: s = {12'd0, r[3:0]} | (16'd1 << $urandom_range(4, 15));
                endcase
                do_write(a, wd, s, $urandom_range(0, 2), $urandom_range(1, 3), msg, lat, h);
                exp_msg = model_write(a, wd, s);
                compared++;
                if (lat !== 1 || msg !== exp_msg || h !== m_halt) begin
                    mismatched++;
                    $display("FAIL rand_write %0d: got lat %0d msg %0d halt %b expected 1 %0d %b",
                             n, lat, msg, h, exp_msg, m_halt);
                end
            end
        end
    endtask

    task automatic test_reset_midflight;
        logic [127:0] d, wd;
        longint unsigned c;
        logic [31:0] msg;
        int lat;
        logic h;
        logic [4:0] got;
        wd = '0;
        wd[31:0] = 32'hCAFE_F00D;
        wd[96] = 1'b1;
        do_write(BASE, wd, 16'h100F, 0, 1, msg, lat, h);
        void'(model_write(BASE, wd, 16'h100F));
        readAddr_addr   = BASE;
        readAddr_valid  = 1'b1;
        readData_ready  = 1'b0;
        writeAddr_addr  = BASE;
        writeAddr_valid = 1'b1;
        tick;
        readAddr_valid  = 1'b0;
        writeAddr_valid = 1'b0;
        compared++;
        if (readData_valid !== 1'b1 || writeAddr_ready !== 1'b0) begin
            mismatched++;
            $display("FAIL midflight_setup: got rvalid %b awready %b expected 1 0",
                     readData_valid, writeAddr_ready);
        end
        tick;
        rst = 1'b0;
        #1;
        got = {readData_valid, writeResp_valid, readAddr_ready,
               writeAddr_ready, writeData_ready};
        compared++;
        if (got !== 5'b00111 || halt_req !== 1'b0) begin
            mismatched++;
            $display("FAIL midflight_reset: got %b halt %b expected 00111 0", got, halt_req);
        end
        readData_ready = 1'b1;
        tick;
        tick;
        rst = 1'b1;
        m_scratch = '0;
        m_halt = 1'b0;
        tick;
        do_read(BASE, d, c, lat);
        compared++;
        if (d !== model_line(BASE, c) || d[31:0] !== 32'd0) begin
            mismatched++;
            $display("FAIL post_reset_read: got %h expected %h", d, model_line(BASE, c));
        end
    endtask

    initial begin
        test_reset;
        test_read_cnt;
        test_write_scratch;
        test_byte_write;
        test_halt;
        test_miss;
        test_concurrent;
        test_random;
        test_reset_midflight;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
